// File: rtl/hazard_ctrl_pkg.sv
// hazard_ctrl_pkg: shared widths and branch FSM encoding for the hazard controller.
package hazard_ctrl_pkg;
  localparam int PC_WIDTH      = 16;
  localparam int NUM_REGS      = 16;
  localparam int REG_IDX_WIDTH = 4;
  localparam int CNT_WIDTH     = 2;
  typedef enum logic {BR_IDLE = 1'b0, BR_WAIT = 1'b1} br_state_e;
endpackage

// File: rtl/hazard_scoreboard.sv
// hazard_scoreboard: per-register pending-writer counts with writeback bypass on source lookup.
module hazard_scoreboard
  import hazard_ctrl_pkg::*;
(
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     inc_i,
  input  logic [REG_IDX_WIDTH-1:0] inc_idx_i,
  input  logic                     dec_i,
  input  logic [REG_IDX_WIDTH-1:0] dec_idx_i,
  input  logic                     src1_vld_i,
  input  logic [REG_IDX_WIDTH-1:0] src1_i,
  input  logic                     src2_vld_i,
  input  logic [REG_IDX_WIDTH-1:0] src2_i,
  output logic                     busy_o,
  output logic                     err_o
);
  logic [CNT_WIDTH-1:0] cnt_q [NUM_REGS];
  logic [CNT_WIDTH-1:0] cnt_d [NUM_REGS];
  logic same, busy1, busy2;
  // a writeback retiring the source this cycle lowers its effective count by one
  assign busy1  = src1_vld_i & (cnt_q[src1_i] > {1'b0, dec_i && dec_idx_i == src1_i});
  assign busy2  = src2_vld_i & (cnt_q[src2_i] > {1'b0, dec_i && dec_idx_i == src2_i});
  assign busy_o = busy1 | busy2;
  assign same   = inc_i & dec_i & (inc_idx_i == dec_idx_i);
  always_comb begin
    cnt_d = cnt_q;
    err_o = 1'b0;
    if (inc_i && !same) begin
      if (cnt_q[inc_idx_i] == 2'd3) err_o = 1'b1;
      else cnt_d[inc_idx_i] = cnt_q[inc_idx_i] + 2'd1;
    end
    if (dec_i && !same) begin
      if (cnt_q[dec_idx_i] == 2'd0) err_o = 1'b1;
      else cnt_d[dec_idx_i] = cnt_q[dec_idx_i] - 2'd1;
    end
  end
  always_ff @(negedge clk) begin
    if (rst) cnt_q <= '{default: '0};
    else cnt_q <= cnt_d;
  end
endmodule

// File: rtl/hazard_ctrl.sv
// hazard_ctrl: dependency and branch stall control with fetch redirect, stall counter and protocol flag.
module hazard_ctrl
  import hazard_ctrl_pkg::*;
(
  input  logic                     I_CLOCK,
  input  logic                     I_RESET,
  input  logic                     I_LOCK,
  input  logic                     I_DE_Valid,
  input  logic [PC_WIDTH-1:0]      I_DE_PC,
  input  logic                     I_DE_IsBranch,
  input  logic [REG_IDX_WIDTH-1:0] I_DE_Src1,
  input  logic [REG_IDX_WIDTH-1:0] I_DE_Src2,
  input  logic                     I_DE_Src1Vld,
  input  logic                     I_DE_Src2Vld,
  input  logic                     I_DE_WrEn,
  input  logic [REG_IDX_WIDTH-1:0] I_DE_Dest,
  input  logic                     I_MEM_BrResolve,
  input  logic                     I_MEM_BrTaken,
  input  logic [PC_WIDTH-1:0]      I_MEM_BrTarget,
  input  logic                     I_WB_WrEn,
  input  logic [REG_IDX_WIDTH-1:0] I_WB_Dest,
  output logic                     O_DepStallSignal,
  output logic                     O_BranchStallSignal,
  output logic                     O_BranchAddrSelect,
  output logic [PC_WIDTH-1:0]      O_BranchPC,
  output logic [15:0]              O_StallCycles,
  output logic                     O_ProtoErr
);
  br_state_e state_q, state_d;
  logic [PC_WIDTH-1:0] ft_q, ft_d, pc_q, pc_d;
  logic [15:0] stall_q, stall_d;
  logic sel_q, sel_d, err_q, err_d, rst, issue, src_busy, sb_err;
  assign rst                 = I_RESET | ~I_LOCK;
  assign O_DepStallSignal    = I_LOCK & I_DE_Valid & src_busy;
  assign issue               = I_DE_Valid & ~O_DepStallSignal & (state_q == BR_IDLE);
  assign O_BranchStallSignal = I_LOCK & ((state_q == BR_WAIT) | (issue & I_DE_IsBranch));
  assign O_BranchAddrSelect  = sel_q;
  assign O_BranchPC          = pc_q;
  assign O_StallCycles       = stall_q;
  assign O_ProtoErr          = err_q;
  hazard_scoreboard u_sb (
    .clk        (I_CLOCK),
    .rst        (rst),
    .inc_i      (issue & I_DE_WrEn),
    .inc_idx_i  (I_DE_Dest),
    .dec_i      (I_WB_WrEn),
    .dec_idx_i  (I_WB_Dest),
    .src1_vld_i (I_DE_Src1Vld),
    .src1_i     (I_DE_Src1),
    .src2_vld_i (I_DE_Src2Vld),
    .src2_i     (I_DE_Src2),
    .busy_o     (src_busy),
    .err_o      (sb_err)
  );
  always_comb begin
    state_d = state_q;
    ft_d    = ft_q;
    pc_d    = pc_q;
    sel_d   = 1'b0;
    if (state_q == BR_IDLE) begin
      if (issue && I_DE_IsBranch) begin
        state_d = BR_WAIT;
        ft_d    = I_DE_PC;
      end
    end else if (I_MEM_BrResolve) begin
      state_d = BR_IDLE;
      sel_d   = 1'b1;
      pc_d    = I_MEM_BrTaken ? I_MEM_BrTarget : ft_q;
    end
    err_d   = err_q | sb_err | (I_MEM_BrResolve & (state_q == BR_IDLE));
    stall_d = (stall_q != 16'hFFFF && (O_DepStallSignal || O_BranchStallSignal)) ? stall_q + 16'd1 : stall_q;
  end
  always_ff @(negedge I_CLOCK) begin
    if (rst) begin
      state_q <= BR_IDLE;
      ft_q    <= '0;
      pc_q    <= '0;
      sel_q   <= 1'b0;
      err_q   <= 1'b0;
      stall_q <= '0;
    end else begin
      state_q <= state_d;
      ft_q    <= ft_d;
      pc_q    <= pc_d;
      sel_q   <= sel_d;
      err_q   <= err_d;
      stall_q <= stall_d;
    end
  end
endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed per-cycle vectors queued by stimulus, checked by an independent monitor.
module tb_hazard_ctrl;
  import hazard_ctrl_pkg::*;
  logic I_CLOCK = 1'b0;
  logic I_RESET, I_LOCK, I_DE_Valid, I_DE_IsBranch, I_DE_Src1Vld, I_DE_Src2Vld, I_DE_WrEn;
  logic I_MEM_BrResolve, I_MEM_BrTaken, I_WB_WrEn;
  logic [PC_WIDTH-1:0] I_DE_PC, I_MEM_BrTarget;
  logic [REG_IDX_WIDTH-1:0] I_DE_Src1, I_DE_Src2, I_DE_Dest, I_WB_Dest;
  logic O_DepStallSignal, O_BranchStallSignal, O_BranchAddrSelect, O_ProtoErr;
  logic [PC_WIDTH-1:0] O_BranchPC;
  logic [15:0] O_StallCycles;
  int tests = 0, fails = 0;
  typedef struct {
    string name;
    logic  dep, bst, sel, err;
    int    pc, cnt;
  } exp_t;
  exp_t q[$];
  always #5 I_CLOCK = ~I_CLOCK;
  hazard_ctrl dut (
    .I_CLOCK(I_CLOCK), .I_RESET(I_RESET), .I_LOCK(I_LOCK),
    .I_DE_Valid(I_DE_Valid), .I_DE_PC(I_DE_PC), .I_DE_IsBranch(I_DE_IsBranch),
    .I_DE_Src1(I_DE_Src1), .I_DE_Src2(I_DE_Src2),
    .I_DE_Src1Vld(I_DE_Src1Vld), .I_DE_Src2Vld(I_DE_Src2Vld),
    .I_DE_WrEn(I_DE_WrEn), .I_DE_Dest(I_DE_Dest),
    .I_MEM_BrResolve(I_MEM_BrResolve), .I_MEM_BrTaken(I_MEM_BrTaken), .I_MEM_BrTarget(I_MEM_BrTarget),
    .I_WB_WrEn(I_WB_WrEn), .I_WB_Dest(I_WB_Dest),
    .O_DepStallSignal(O_DepStallSignal), .O_BranchStallSignal(O_BranchStallSignal),
    .O_BranchAddrSelect(O_BranchAddrSelect), .O_BranchPC(O_BranchPC),
    .O_StallCycles(O_StallCycles), .O_ProtoErr(O_ProtoErr)
  );
  task automatic chk(string n, int act, int exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", n, act, exp);
    end
  endtask
  // monitor: outputs are stable at posedge, half a cycle from the negedge state update
  initial forever begin
    exp_t e;
    @(posedge I_CLOCK);
    if (q.size() > 0) begin
      e = q.pop_front();
      chk({e.name, ".dep"}, int'(O_DepStallSignal), int'(e.dep));
      chk({e.name, ".bstall"}, int'(O_BranchStallSignal), int'(e.bst));
      chk({e.name, ".addrsel"}, int'(O_BranchAddrSelect), int'(e.sel));
      chk({e.name, ".protoerr"}, int'(O_ProtoErr), int'(e.err));
      if (e.pc >= 0) chk({e.name, ".pc"}, int'(O_BranchPC), e.pc);
      if (e.cnt >= 0) chk({e.name, ".stallcnt"}, int'(O_StallCycles), e.cnt);
    end
  end
  task automatic idle();
    I_DE_Valid = 0; I_DE_PC = '0; I_DE_IsBranch = 0;
    I_DE_Src1 = '0; I_DE_Src2 = '0; I_DE_Src1Vld = 0; I_DE_Src2Vld = 0;
    I_DE_WrEn = 0; I_DE_Dest = '0;
    I_MEM_BrResolve = 0; I_MEM_BrTaken = 0; I_MEM_BrTarget = '0;
    I_WB_WrEn = 0; I_WB_Dest = '0;
  endtask
  task automatic de(logic w, logic [3:0] d, logic s1v, logic [3:0] s1, logic s2v, logic [3:0] s2);
    I_DE_Valid = 1; I_DE_WrEn = w; I_DE_Dest = d;
    I_DE_Src1Vld = s1v; I_DE_Src1 = s1; I_DE_Src2Vld = s2v; I_DE_Src2 = s2;
  endtask
  task automatic wb(logic [3:0] d);
    I_WB_WrEn = 1; I_WB_Dest = d;
  endtask
  task automatic br(logic [15:0] pc);
    I_DE_Valid = 1; I_DE_IsBranch = 1; I_DE_PC = pc;
  endtask
  task automatic res(logic t, logic [15:0] tgt);
    I_MEM_BrResolve = 1; I_MEM_BrTaken = t; I_MEM_BrTarget = tgt;
  endtask
  task automatic cyc(string n, logic dep, logic bst, logic sel, logic err, int pc = -1, int cnt = -1);
    exp_t e;
    e.name = n; e.dep = dep; e.bst = bst; e.sel = sel; e.err = err; e.pc = pc; e.cnt = cnt;
    q.push_back(e);
    @(negedge I_CLOCK);
    #1;
    idle();
  endtask
  initial begin
    I_RESET = 1; I_LOCK = 1; idle();
    @(negedge I_CLOCK);
    #1;
    I_RESET = 0;
    cyc("reset", 0, 0, 0, 0, 0, 0);
    de(1, 3, 0, 0, 0, 0);            cyc("iss_w3", 0, 0, 0, 0, -1, 0);
    de(0, 0, 1, 3, 0, 0);            cyc("rd3_a", 1, 0, 0, 0, -1, 0);
    de(0, 0, 1, 3, 0, 0);            cyc("rd3_b", 1, 0, 0, 0, -1, 1);
    de(0, 0, 1, 3, 0, 0); wb(3);     cyc("rd3_retire", 0, 0, 0, 0, -1, 2);
    de(0, 0, 1, 3, 0, 0);            cyc("rd3_after", 0, 0, 0, 0, -1, 2);
    br(16'h0010);                    cyc("tk_issue", 0, 1, 0, 0, -1, 2);
                                     cyc("tk_wait1", 0, 1, 0, 0, -1, 3);
    de(1, 9, 0, 0, 0, 0);            cyc("tk_wait2", 0, 1, 0, 0, -1, 4);
    res(1, 16'h0040);                cyc("tk_resolve", 0, 1, 0, 0, -1, 5);
                                     cyc("tk_pulse", 0, 0, 1, 0, 16'h0040, 6);
    de(0, 0, 1, 9, 0, 0);            cyc("tk_hold", 0, 0, 0, 0, 16'h0040, 6);
    br(16'h0010);                    cyc("nt_issue", 0, 1, 0, 0, 16'h0040, 6);
                                     cyc("nt_wait1", 0, 1, 0, 0, -1, 7);
                                     cyc("nt_wait2", 0, 1, 0, 0, -1, 8);
    res(0, 16'h0040);                cyc("nt_resolve", 0, 1, 0, 0, -1, 9);
                                     cyc("nt_pulse", 0, 0, 1, 0, 16'h0010, 10);
                                     cyc("nt_hold", 0, 0, 0, 0, 16'h0010, 10);
    de(1, 5, 0, 0, 0, 0);            cyc("w5_a", 0, 0, 0, 0);
    de(1, 5, 0, 0, 0, 0); wb(5);     cyc("w5_wb5", 0, 0, 0, 0);
    de(0, 0, 0, 0, 1, 5);            cyc("rd5", 1, 0, 0, 0, -1, 10);
    de(0, 0, 0, 0, 1, 5); wb(5);     cyc("rd5_wb", 0, 0, 0, 0, -1, 11);
    for (int i = 0; i < 4; i++) begin
      de(1, 7, 0, 0, 0, 0);          cyc($sformatf("w7_%0d", i), 0, 0, 0, 0);
    end
    de(0, 0, 1, 7, 0, 0); wb(7);     cyc("r7_wb_a", 1, 0, 0, 1);
    de(0, 0, 1, 7, 0, 0); wb(7);     cyc("r7_wb_b", 1, 0, 0, 1);
    de(0, 0, 1, 7, 0, 0); wb(7);     cyc("r7_wb_c", 0, 0, 0, 1);
    de(1, 7, 0, 0, 0, 0);            cyc("w7_pre_rst", 0, 0, 0, 1, 16'h0010);
    I_RESET = 1;                     cyc("rst_pulse", 0, 0, 0, 1, 16'h0010);
    I_RESET = 0;
    de(0, 0, 1, 7, 0, 0);            cyc("rst_after", 0, 0, 0, 0, 0, 0);
    br(16'h0020);                    cyc("rb_issue", 0, 1, 0, 0, 0);
                                     cyc("rb_wait", 0, 1, 0, 0);
    I_RESET = 1;                     cyc("rb_rst", 0, 1, 0, 0);
    I_RESET = 0;
    res(1, 16'h0080);                cyc("rb_resolve", 0, 0, 0, 0, 0);
                                     cyc("rb_nopulse", 0, 0, 0, 1, 0);
    de(1, 2, 0, 0, 0, 0);            cyc("w2", 0, 0, 0, 1);
    I_LOCK = 0; de(0, 0, 1, 2, 0, 0); I_DE_IsBranch = 1;
                                     cyc("lock_low", 0, 0, 0, 1);
    I_LOCK = 1;
    de(0, 0, 1, 2, 0, 0);            cyc("lock_after", 0, 0, 0, 0, 0, 0);
    @(posedge I_CLOCK);
    #1;
    chk("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
